// File: rtl/tx_symbol_scheduler.sv
// rtl/tx_symbol_scheduler.sv - per-cycle symbol selection ahead of the 8b/10b encoder
module tx_symbol_scheduler #(
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_COUNT    = 3,
    parameter int CNT_W        = 11
) (
    input  logic       INTERCLK,
    input  logic       Reset,
    input  logic       iValid,
    input  logic [7:0] iData,
    input  logic       iLast,
    output logic       oReady,
    output logic [7:0] oTxData,
    output logic       oTxDataK,
    output logic       oSkpActive,
    output logic       oUnderrun,
    output logic       oSkpOverrun
);

    localparam logic [7:0] SYM_STP  = 8'hFB;
    localparam logic [7:0] SYM_END  = 8'hFD;
    localparam logic [7:0] SYM_COM  = 8'hBC;
    localparam logic [7:0] SYM_SKP  = 8'h1C;
    localparam logic [7:0] SYM_PAD  = 8'hF7;
    localparam logic [7:0] SYM_IDLE = 8'h00;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SKP_INTERVAL - 1);
    localparam logic [2:0]       IDX_LAST = 3'(SKP_COUNT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STP,
        ST_DATA,
        ST_END,
        ST_COM,
        ST_SKP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             skp_pending_q, skp_pending_d;
    logic [2:0]       skp_idx_q, skp_idx_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_k_q, tx_k_d;
    logic             skp_active_q, skp_active_d;
    logic             underrun_q, underrun_d;
    logic             overrun_q, overrun_d;

    state_t boundary_next;
    logic   cnt_tick;
    logic   cnt_wrap;

    // A SKP set owed always beats a packet waiting at a boundary.
    always_comb begin
        boundary_next = ST_IDLE;
        if (skp_pending_q) begin
            boundary_next = ST_COM;
        end else if (iValid) begin
            boundary_next = ST_STP;
        end
    end

    always_comb begin
        state_d       = state_q;
        skp_idx_d     = skp_idx_q;
        tx_data_d     = SYM_IDLE;
        tx_k_d        = 1'b0;
        skp_active_d  = 1'b0;
        underrun_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = boundary_next;
            end
            ST_STP: begin
                tx_data_d = SYM_STP;
                tx_k_d    = 1'b1;
                state_d   = ST_DATA;
            end
            ST_DATA: begin
                if (iValid) begin
                    tx_data_d = iData;
                    if (iLast) begin
                        state_d = ST_END;
                    end
                end else begin
                    tx_data_d  = SYM_PAD;
                    tx_k_d     = 1'b1;
                    underrun_d = 1'b1;
                end
            end
            ST_END: begin
                tx_data_d = SYM_END;
                tx_k_d    = 1'b1;
                state_d   = boundary_next;
            end
            ST_COM: begin
                tx_data_d    = SYM_COM;
                tx_k_d       = 1'b1;
                skp_active_d = 1'b1;
                skp_idx_d    = 3'd0;
                state_d      = ST_SKP;
            end
            ST_SKP: begin
                tx_data_d    = SYM_SKP;
                tx_k_d       = 1'b1;
                skp_active_d = 1'b1;
                if (skp_idx_q == IDX_LAST) begin
                    state_d = boundary_next;
                end else begin
                    skp_idx_d = skp_idx_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The interval clock freezes while a SKP set is on the wire.
    assign cnt_tick = (state_q != ST_COM) && (state_q != ST_SKP);
    assign cnt_wrap = cnt_tick && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d         = cnt_q;
        skp_pending_d = skp_pending_q;
        overrun_d     = 1'b0;

        if (state_d == ST_COM) begin
            skp_pending_d = 1'b0;
        end
        if (cnt_wrap) begin
            cnt_d         = '0;
            skp_pending_d = 1'b1;
            overrun_d     = skp_pending_q;
        end else if (cnt_tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge INTERCLK) begin
        if (!Reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            skp_pending_q <= 1'b0;
            skp_idx_q     <= 3'd0;
            tx_data_q     <= SYM_IDLE;
            tx_k_q        <= 1'b0;
            skp_active_q  <= 1'b0;
            underrun_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            skp_pending_q <= skp_pending_d;
            skp_idx_q     <= skp_idx_d;
            tx_data_q     <= tx_data_d;
            tx_k_q        <= tx_k_d;
            skp_active_q  <= skp_active_d;
            underrun_q    <= underrun_d;
            overrun_q     <= overrun_d;
        end
    end

    assign oReady      = (state_q == ST_DATA);
    assign oTxData     = tx_data_q;
    assign oTxDataK    = tx_k_q;
    assign oSkpActive  = skp_active_q;
    assign oUnderrun   = underrun_q;
    assign oSkpOverrun = overrun_q;

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// tb/tb_tx_symbol_scheduler.sv - randomized bench for tx_symbol_scheduler against a symbol-level model
module tb_tx_symbol_scheduler;

    localparam int SKP_INTERVAL = 16;
    localparam int SKP_COUNT    = 3;
    localparam int CNT_W        = 5;

    logic       INTERCLK = 1'b0;
    logic       Reset;
    logic       iValid;
    logic [7:0] iData;
    logic       iLast;
    logic       oReady;
    logic [7:0] oTxData;
    logic       oTxDataK;
    logic       oSkpActive;
    logic       oUnderrun;
    logic       oSkpOverrun;

    always #5 INTERCLK = ~INTERCLK;

    tx_symbol_scheduler #(
        .SKP_INTERVAL(SKP_INTERVAL),
        .SKP_COUNT   (SKP_COUNT),
        .CNT_W       (CNT_W)
    ) dut (
        .INTERCLK   (INTERCLK),
        .Reset      (Reset),
        .iValid     (iValid),
        .iData      (iData),
        .iLast      (iLast),
        .oReady     (oReady),
        .oTxData    (oTxData),
        .oTxDataK   (oTxDataK),
        .oSkpActive (oSkpActive),
        .oUnderrun  (oUnderrun),
        .oSkpOverrun(oSkpOverrun)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // upstream byte stream: data, last flag, idle cycles before presenting
    logic [7:0] q_data[$];
    bit         q_last[$];
    int         q_gap[$];
    bit         xfer = 1'b0;

    logic [8:0] sym_log[$];
    int         und_cnt;
    int         ovr_cnt;

    // model: what the wire owes next, expressed as pending obligations
    int         m_skp_left;
    bit         m_stp, m_pay, m_end, m_owed;
    int         m_cnt;
    logic [7:0] e_data;
    bit         e_k, e_act, e_und, e_ovr;

    function automatic logic [12:0] dut_vec();
        return {oTxData, oTxDataK, oSkpActive, oUnderrun, oSkpOverrun, oReady};
    endfunction

    function automatic logic [12:0] exp_vec();
        return {e_data, e_k, e_act, e_und, e_ovr, m_pay};
    endfunction

    task automatic model_edge(input bit rn, input bit v, input logic [7:0] d, input bit l);
        bit in_set, owed_before, enter;
        if (!rn) begin
            m_skp_left = 0; m_stp = 0; m_pay = 0; m_end = 0; m_cnt = 0; m_owed = 0;
            e_data = 8'h00; e_k = 0; e_act = 0; e_und = 0; e_ovr = 0;
            return;
        end
        in_set      = (m_skp_left > 0);
        owed_before = m_owed;
        enter       = 0;
        e_act = 0; e_und = 0; e_ovr = 0;
        if (in_set) begin
            e_data = (m_skp_left == SKP_COUNT + 1) ? 8'hBC : 8'h1C;
            e_k = 1; e_act = 1;
        end else if (m_stp) begin
            e_data = 8'hFB; e_k = 1;
        end else if (m_pay) begin
            if (v) begin e_data = d; e_k = 0; end
            else begin e_data = 8'hF7; e_k = 1; e_und = 1; end
        end else if (m_end) begin
            e_data = 8'hFD; e_k = 1;
        end else begin
            e_data = 8'h00; e_k = 0;
        end
        if (m_skp_left > 1) begin
            m_skp_left--;
        end else if (m_stp) begin
            m_stp = 0; m_pay = 1;
        end else if (m_pay) begin
            if (v && l) begin m_pay = 0; m_end = 1; end
        end else begin
            m_skp_left = 0; m_end = 0;
            if (owed_before) begin m_skp_left = SKP_COUNT + 1; enter = 1; end
            else if (v) m_stp = 1;
        end
        if (enter) m_owed = 0;
        if (!in_set) begin
            m_cnt++;
            if (m_cnt == SKP_INTERVAL) begin
                m_cnt = 0; e_ovr = owed_before; m_owed = 1;
            end
        end
    endtask

    task automatic cycle();
        if (xfer) begin
            void'(q_data.pop_front()); void'(q_last.pop_front()); void'(q_gap.pop_front());
        end
        if (q_data.size() == 0) begin
            iValid = 1'b0;
        end else if (!(iValid && !xfer)) begin
            if (q_gap[0] > 0) begin
                q_gap[0] = q_gap[0] - 1;
                iValid = 1'b0;
            end else begin
                iValid = 1'b1; iData = q_data[0]; iLast = q_last[0];
            end
        end
        @(posedge INTERCLK);
        xfer = iValid && m_pay && Reset;
        model_edge(Reset, iValid, iData, iLast);
        @(negedge INTERCLK);
        cyc++;
        sym_log.push_back({oTxDataK, oTxData});
        und_cnt += int'(oUnderrun);
        ovr_cnt += int'(oSkpOverrun);
    endtask

    task automatic add_byte(input logic [7:0] d, input bit l, input int gap);
        q_data.push_back(d); q_last.push_back(l); q_gap.push_back(gap);
    endtask

    task automatic add_pkt(input int len, input int gap_pct, input int gap_max);
        for (int i = 0; i < len; i++) begin
            add_byte(8'($urandom_range(0, 255)), (i == len - 1),
                     ($urandom_range(0, 99) < gap_pct) ? int'($urandom_range(1, gap_max)) : 0);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        q_data.delete(); q_last.delete(); q_gap.delete();
        cycle();
        cycle();
        Reset = 1'b1;
        sym_log.delete(); und_cnt = 0; ovr_cnt = 0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        q_data.delete(); q_last.delete(); q_gap.delete();
        add_byte(8'hAA, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (dut_vec() !== 13'h0)
                begin errors++; $display("FAIL reset_hold cyc %0d got %h exp %h", cyc, dut_vec(), 13'h0); end
        end
        Reset = 1'b1;
        cycle();
        checks++;
        if (dut_vec() !== exp_vec())
            begin errors++; $display("FAIL reset_release cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec()); end
        cycle();
        checks++;
        if ({oTxDataK, oTxData} !== 9'h1FB)
            begin errors++; $display("FAIL reset_stp cyc %0d got %h exp %h", cyc, {oTxDataK, oTxData}, 9'h1FB); end
        Reset = 1'b0;
        cycle();
        checks++;
        if (dut_vec() !== 13'h0)
            begin errors++; $display("FAIL reset_abort cyc %0d got %h exp %h", cyc, dut_vec(), 13'h0); end
    endtask

    task automatic test_single_packet();
        logic [8:0] exp_s[8] = '{9'h1FB, 9'h011, 9'h022, 9'h033, 9'h044, 9'h1FD, 9'h000, 9'h000};
        int start;
        do_reset();
        add_byte(8'h11, 0, 0); add_byte(8'h22, 0, 0); add_byte(8'h33, 0, 0); add_byte(8'h44, 1, 0);
        for (int i = 0; i < 12; i++) begin
            cycle();
            checks++;
            if (dut_vec() !== exp_vec())
                begin errors++; $display("FAIL single_model cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec()); end
        end
        start = -1;
        for (int i = 0; i < sym_log.size(); i++) if (start < 0 && sym_log[i] == 9'h1FB) start = i;
        checks++;
        if (start < 0 || start + 8 > sym_log.size()) begin
            errors++; $display("FAIL single_stp_found got %0d exp present", start);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (sym_log[start + i] !== exp_s[i])
                    begin errors++; $display("FAIL single_stream idx %0d got %h exp %h", i, sym_log[start + i], exp_s[i]); end
            end
        end
    endtask

    task automatic test_underrun();
        logic [8:0] exp_s[10] = '{9'h1FB, 9'h0A1, 9'h0A2, 9'h0A3, 9'h1F7, 9'h1F7,
                                  9'h0A4, 9'h0A5, 9'h0A6, 9'h1FD};
        int start;
        do_reset();
        add_byte(8'hA1, 0, 0); add_byte(8'hA2, 0, 0); add_byte(8'hA3, 0, 0);
        add_byte(8'hA4, 0, 2); add_byte(8'hA5, 0, 0); add_byte(8'hA6, 1, 0);
        for (int i = 0; i < 15; i++) begin
            cycle();
            checks++;
            if (dut_vec() !== exp_vec())
                begin errors++; $display("FAIL underrun_model cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec()); end
        end
        checks++;
        if (und_cnt !== 2)
            begin errors++; $display("FAIL underrun_pulses got %0d exp %0d", und_cnt, 2); end
        start = -1;
        for (int i = 0; i < sym_log.size(); i++) if (start < 0 && sym_log[i] == 9'h1FB) start = i;
        if (start < 0 || start + 10 > sym_log.size()) begin
            checks++; errors++; $display("FAIL underrun_stp_found got %0d exp present", start);
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (sym_log[start + i] !== exp_s[i])
                    begin errors++; $display("FAIL underrun_stream idx %0d got %h exp %h", i, sym_log[start + i], exp_s[i]); end
            end
        end
    endtask

    task automatic test_skp_idle();
        int coms[$];
        do_reset();
        for (int i = 0; i < 50; i++) begin
            cycle();
            checks++;
            if (dut_vec() !== exp_vec())
                begin errors++; $display("FAIL skp_idle_model cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec()); end
        end
        for (int i = 0; i < sym_log.size(); i++) if (sym_log[i] == 9'h1BC) coms.push_back(i);
        checks++;
        if (coms.size() < 2) begin
            errors++; $display("FAIL skp_idle_sets got %0d exp 2", coms.size());
        end else begin
            for (int j = 1; j <= SKP_COUNT; j++) begin
                checks++;
                if (sym_log[coms[0] + j] !== 9'h11C)
                    begin errors++; $display("FAIL skp_idle_skp idx %0d got %h exp %h", j, sym_log[coms[0] + j], 9'h11C); end
            end
            checks++;
            if (coms[1] - coms[0] !== SKP_INTERVAL + SKP_COUNT + 1)
                begin errors++; $display("FAIL skp_idle_period got %0d exp %0d", coms[1] - coms[0], SKP_INTERVAL + SKP_COUNT + 1); end
        end
    endtask

    task automatic test_skp_deferred();
        logic [8:0] exp_s[5] = '{9'h1BC, 9'h11C, 9'h11C, 9'h11C, 9'h1FB};
        int stp, fin;
        do_reset();
        add_pkt(30, 0, 1);
        add_pkt(3, 0, 1);
        for (int i = 0; i < 50; i++) begin
            cycle();
            checks++;
            if (dut_vec() !== exp_vec())
                begin errors++; $display("FAIL deferred_model cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec()); end
        end
        stp = -1; fin = -1;
        for (int i = 0; i < sym_log.size(); i++) begin
            if (stp < 0 && sym_log[i] == 9'h1FB) stp = i;
            if (fin < 0 && sym_log[i] == 9'h1FD) fin = i;
        end
        checks++;
        if (stp < 0 || fin < stp || fin + 6 > sym_log.size()) begin
            errors++; $display("FAIL deferred_frame got stp %0d end %0d exp framed", stp, fin);
        end else begin
            for (int i = stp; i < fin; i++) begin
                checks++;
                if (sym_log[i] == 9'h1BC)
                    begin errors++; $display("FAIL deferred_com_in_pkt idx %0d got %h exp not %h", i, sym_log[i], 9'h1BC); end
            end
            for (int j = 0; j < 5; j++) begin
                checks++;
                if (sym_log[fin + 1 + j] !== exp_s[j])
                    begin errors++; $display("FAIL deferred_after_end idx %0d got %h exp %h", j, sym_log[fin + 1 + j], exp_s[j]); end
            end
        end
    endtask

    task automatic test_overrun();
        int n_com;
        do_reset();
        add_pkt(40, 0, 1);
        for (int i = 0; i < 50; i++) begin
            cycle();
            checks++;
            if (dut_vec() !== exp_vec())
                begin errors++; $display("FAIL overrun_model cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec()); end
        end
        n_com = 0;
        for (int i = 0; i < sym_log.size(); i++) if (sym_log[i] == 9'h1BC) n_com++;
        checks++;
        if (ovr_cnt !== 1)
            begin errors++; $display("FAIL overrun_pulses got %0d exp %0d", ovr_cnt, 1); end
        checks++;
        if (n_com !== 1)
            begin errors++; $display("FAIL overrun_sets got %0d exp %0d", n_com, 1); end
    endtask

    task automatic test_back_to_back();
        int n_stp, n_end, guard;
        do_reset();
        for (int p = 0; p < 8; p++) add_pkt(int'($urandom_range(1, 5)), 0, 1);
        guard = 0;
        while ((q_data.size() != 0 || m_pay || m_end || m_stp || m_skp_left != 0) && guard < 500) begin
            cycle();
            guard++;
            checks++;
            if (dut_vec() !== exp_vec())
                begin errors++; $display("FAIL b2b_model cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec()); end
        end
        checks++;
        if (guard >= 500)
            begin errors++; $display("FAIL b2b_timeout got %0d exp <500", guard); end
        n_stp = 0; n_end = 0;
        for (int i = 0; i < sym_log.size(); i++) begin
            if (sym_log[i] == 9'h1FB) n_stp++;
            if (sym_log[i] == 9'h1FD) begin
                n_end++;
                if (i + 1 < sym_log.size() && n_end < 8) begin
                    checks++;
                    if (sym_log[i + 1] !== 9'h1FB && sym_log[i + 1] !== 9'h1BC)
                        begin errors++; $display("FAIL b2b_gap idx %0d got %h exp STP or COM", i, sym_log[i + 1]); end
                end
            end
        end
        checks++;
        if (n_stp !== 8 || n_end !== 8)
            begin errors++; $display("FAIL b2b_counts got %0d/%0d exp 8/8", n_stp, n_end); end
    endtask

    task automatic test_random();
        int guard, tail;
        do_reset();
        for (int p = 0; p < 12; p++) add_pkt(int'($urandom_range(1, 24)), 25, 3);
        guard = 0; tail = 0;
        while (tail < 20 && guard < 3000) begin
            cycle();
            guard++;
            if (q_data.size() == 0) tail++;
            checks++;
            if (dut_vec() !== exp_vec())
                begin errors++; $display("FAIL random_model cyc %0d got %h exp %h", cyc, dut_vec(), exp_vec()); end
        end
        checks++;
        if (guard >= 3000)
            begin errors++; $display("FAIL random_timeout got %0d exp <3000", guard); end
    endtask

    initial begin
        Reset  = 1'b0;
        iValid = 1'b0;
        iData  = 8'h00;
        iLast  = 1'b0;
        und_cnt = 0;
        ovr_cnt = 0;
        model_edge(1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge INTERCLK);
        test_reset();
        test_single_packet();
        test_underrun();
        test_skp_idle();
        test_skp_deferred();
        test_overrun();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_symbol_scheduler.md
# tx_symbol_scheduler

Transmit-side symbol scheduler that sits directly in front of the 8b/10b encoder and decides, every INTERCLK cycle, which byte and K flag the encoder codes. It frames upstream packets with STP/END control symbols, fills gaps with logical idle, and periodically inserts SKP ordered sets (COM + N×SKP) at packet boundaries. Its outputs drive the encoder's data and TXDATAK inputs one-for-one, one symbol per cycle.

## Interface
Parameters:
- SKP_INTERVAL, 1180, number of non-SKP symbols between SKP insertion requests (≥ 4)
- SKP_COUNT, 3, SKP symbols following each COM (1..7)
- CNT_W, 11, width of the interval counter; must satisfy 2^CNT_W > SKP_INTERVAL

Ports:
- INTERCLK  in  1  internal clock, all logic on rising edge
- Reset  in  1  reset, synchronous, active-low
- iValid  in  1  upstream payload byte valid
- iData  in  8  upstream payload byte
- iLast  in  1  qualifies iData as last byte of packet
- oReady  out  1  scheduler accepts iData this cycle
- oTxData  out  8  byte to encoder iData
- oTxDataK  out  1  to encoder TXDATAK (1 = control symbol)
- oSkpActive  out  1  current oTxData is COM or SKP
- oUnderrun  out  1  one-cycle pulse: PAD emitted inside a packet
- oSkpOverrun  out  1  one-cycle pulse: interval expired while a SKP was still pending

## Operation
- Control codes: STP 0xFB, END 0xFD, COM 0xBC (K28.5), SKP 0x1C (K28.0), PAD 0xF7; idle = 0x00 with K=0.
- State register names the symbol emitted at the next edge: IDLE, STP, DATA, END, COM, SKP. At each edge the outputs load symbol(state) and state advances.
- symbol: IDLE→0x00/K0; STP→0xFB/K1; DATA→iData/K0 if iValid else 0xF7/K1 (+oUnderrun); END→0xFD/K1; COM→0xBC/K1; SKP→0x1C/K1.
- Transitions:
  - IDLE, END, and SKP (last): skp_pending→COM; else iValid→STP; else IDLE. skp_pending has priority over a waiting packet.
  - STP→DATA.
  - DATA: iValid & iLast→END; else DATA.
  - COM→SKP with skp_idx=0. SKP: skp_idx increments; leaves after skp_idx==SKP_COUNT-1.
- oReady = (state==DATA). A transfer occurs on an edge with iValid & oReady. Upstream must hold iData/iLast stable while iValid & ~oReady.
- Interval counter cnt increments on every edge where state ∉ {COM, SKP}. When cnt==SKP_INTERVAL-1: cnt←0 and skp_pending←1. If skp_pending is already 1, oSkpOverrun pulses; only one SKP set is owed.
- skp_pending clears on the edge that enters COM. A simultaneous wrap wins: pending stays 1.
- A SKP set is never inserted inside a packet. Pending waits through DATA until END.
- oSkpActive = 1 while oTxData carries COM or SKP.

## Timing
- Reset (Reset==0 at an edge) loads: state=IDLE, oTxData=0x00, oTxDataK=0, oReady=0, oSkpActive=0, oUnderrun=0, oSkpOverrun=0, cnt=0, skp_pending=0, skp_idx=0.
- Reset mid-packet or mid-SKP aborts immediately. No END or remaining SKPs are emitted.
- All outputs are registered except oReady, which decodes the state register.
- Latency: iValid first sampled in IDLE at edge n → STP on oTxData after n+1 → first payload byte after n+2. Each later byte appears on the edge it transfers.
- Back-to-back packets: END, then STP on the next edge. Minimum inter-packet overhead is 2 symbols (END, STP).
- SKP set length is exactly 1+SKP_COUNT consecutive cycles.

## Test plan
- Reset: hold Reset=0 for 3 edges with iValid=1 → oTxData=0x00, oTxDataK=0, oReady=0 throughout; release → STP one edge later.
- Single packet, SKP_INTERVAL=1180: 4 bytes 0x11,0x22,0x33,0x44 (iLast on 0x44), iValid continuous → stream FB/K1, 11, 22, 33, 44, FD/K1, then 00/K0 idles.
- Underrun: drop iValid for 2 cycles mid-packet → two F7/K1 symbols, oUnderrun high those two cycles, packet resumes, END follows last byte.
- SKP during idle, SKP_INTERVAL=16, SKP_COUNT=3: idle from reset → after 16 idle symbols, BC,1C,1C,1C (K=1, oSkpActive=1) appear. Next set follows 16 non-SKP symbols later.
- SKP deferred by packet, SKP_INTERVAL=16: 30-byte packet spans the expiry → no COM inside the packet. END is immediately followed by BC,1C,1C,1C, then the next waiting packet's STP.
- Overrun: SKP_INTERVAL=16, 40-byte packet → oSkpOverrun pulses once at the second expiry. Only one SKP set is emitted after END.
